// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - multi-digit BCD up/down counter with one-hot digit scanner
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic                  load_err,
    output logic [DIGITS-1:0]     scan_sel,
    output logic [3:0]            scan_digit
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [4*DIGITS-1:0] r_count;
    logic                r_wrap;
    logic                r_load_err;
    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;

    logic [4*DIGITS-1:0] w_step_val;
    logic                w_step_wrap;
    logic [4*DIGITS-1:0] w_load_fix;
    logic                w_load_bad;
    logic                w_slot_end;
    logic [DIGITS-1:0]   w_sel;
    logic [3:0]          w_digit;

    // Ripple the borrow/carry through the digits; a carry out of the MSD is a rollover.
    always_comb begin : step_logic
        logic       carry;
        logic [3:0] d;
        w_step_val = r_count;
        carry      = 1'b1;
        d          = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = r_count[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (d >= 4'd9) begin
                        w_step_val[4*i +: 4] = 4'd0;
                    end else begin
                        w_step_val[4*i +: 4] = d + 4'd1;
                        carry                = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        w_step_val[4*i +: 4] = 4'd9;
                    end else begin
                        w_step_val[4*i +: 4] = d - 4'd1;
                        carry                = 1'b0;
                    end
                end
            end
        end
        w_step_wrap = carry;
    end

    always_comb begin : load_logic
        w_load_fix = load_val;
        w_load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                w_load_fix[4*i +: 4] = 4'd0;
                w_load_bad           = 1'b1;
            end
        end
    end

    assign w_slot_end = (r_pre == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            r_pre      <= '0;
            r_idx      <= '0;
        end else begin
            // Scanner free-runs regardless of load/enable.
            if (w_slot_end) begin
                r_pre <= '0;
                r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end

            if (load) begin
                r_count    <= w_load_fix;
                r_load_err <= w_load_bad;
                r_wrap     <= 1'b0;
            end else if (en) begin
                r_count    <= w_step_val;
                r_wrap     <= w_step_wrap;
                r_load_err <= 1'b0;
            end else begin
                r_wrap     <= 1'b0;
                r_load_err <= 1'b0;
            end
        end
    end

    always_comb begin : scan_logic
        w_sel   = '0;
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_sel[i] = (r_idx == IW'(i));
            if (r_idx == IW'(i)) begin
                w_digit = r_count[4*i +: 4];
            end
        end
    end

    assign count      = r_count;
    assign wrap       = r_wrap;
    assign load_err   = r_load_err;
    assign scan_sel   = w_sel;
    assign scan_digit = w_digit;

endmodule
